// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
package counter_pkg;

    localparam logic CNT_WRAP = 1'b0;
    localparam logic CNT_SAT  = 1'b1;

    // Bits needed to hold values 0..v (at least 1), for sizing WIDTH from a modulus.
    function automatic int clog2(input longint unsigned v);
        int bits;
        bits = 1;
        while ((v >> bits) != 0) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/cnt_next_logic.sv
// Combinational step logic: next count and terminal-count flag for one enabled step.
module cnt_next_logic
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic [WIDTH-1:0] y_i,
    input  logic             dir_i,
    input  logic             en_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] y_next_o,
    output logic             tc_next_o
);

    always_comb begin
        y_next_o  = y_i;
        tc_next_o = 1'b0;
        if (en_i) begin
            if (dir_i) begin
                // >= also pulls an out-of-range value back into the legal range
                if (y_i >= MAX_VAL) begin
                    tc_next_o = 1'b1;
                    y_next_o  = (mode_i == CNT_SAT) ? MAX_VAL : '0;
                end else begin
                    y_next_o = y_i + 1'b1;
                end
            end else begin
                if (y_i == '0) begin
                    tc_next_o = 1'b1;
                    y_next_o  = (mode_i == CNT_SAT) ? '0 : MAX_VAL;
                end else begin
                    y_next_o = y_i - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with clear, load, wrap/saturate mode,
// terminal-count pulse and boundary flags.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int              SAT_MODE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             dir,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] y,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];
    localparam logic             MODE  = (SAT_MODE != 0) ? CNT_SAT : CNT_WRAP;

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("param_updown_counter: WIDTH must be 1..32");
        end
        if (MAX_VAL < 64'd1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
            $error("param_updown_counter: MAX_VAL must be 1..2**WIDTH-1");
        end
        if (SAT_MODE != 0 && SAT_MODE != 1) begin : g_bad_mode
            $error("param_updown_counter: SAT_MODE must be 0 or 1");
        end
    endgenerate

    logic [WIDTH-1:0] y_q, y_d, y_step;
    logic             tc_q, tc_d, tc_step;

    cnt_next_logic #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_W)
    ) u_next (
        .y_i       (y_q),
        .dir_i     (dir),
        .en_i      (en),
        .mode_i    (MODE),
        .y_next_o  (y_step),
        .tc_next_o (tc_step)
    );

    // clear beats load beats step; both suppress any boundary tc
    always_comb begin
        y_d  = y_step;
        tc_d = tc_step;
        if (clear) begin
            y_d  = '0;
            tc_d = 1'b0;
        end else if (load) begin
            y_d  = (load_val > MAX_W) ? MAX_W : load_val;
            tc_d = 1'b0;
        end
    end

    // reset_n is active-high despite its name
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            y_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            y_q  <= y_d;
            tc_q <= tc_d;
        end
    end

    assign y      = y_q;
    assign tc     = tc_q;
    assign at_max = (y_q == MAX_W);
    assign at_min = (y_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench: a wrap counter (mod 10) and a saturating counter (0..15).
module tb_param_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: WIDTH=4, MAX_VAL=9, wrap
    logic       rst_a = 1'b1, en_a = 1'b0, dir_a = 1'b0, clr_a = 1'b0, ld_a = 1'b0;
    logic [3:0] lv_a = '0, y_a;
    logic       tc_a, mx_a, mn_a;

    // DUT B: WIDTH=4, MAX_VAL=15, saturate
    logic       rst_b = 1'b1, en_b = 1'b0, dir_b = 1'b0, clr_b = 1'b0, ld_b = 1'b0;
    logic [3:0] lv_b = '0, y_b;
    logic       tc_b, mx_b, mn_b;

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SAT_MODE(0)) dut_a (
        .clk(clk), .reset_n(rst_a), .en(en_a), .dir(dir_a), .clear(clr_a),
        .load(ld_a), .load_val(lv_a), .y(y_a), .tc(tc_a), .at_max(mx_a), .at_min(mn_a)
    );

    param_updown_counter #(.WIDTH(4), .MAX_VAL(15), .SAT_MODE(1)) dut_b (
        .clk(clk), .reset_n(rst_b), .en(en_b), .dir(dir_b), .clear(clr_b),
        .load(ld_b), .load_val(lv_b), .y(y_b), .tc(tc_b), .at_max(mx_b), .at_min(mn_b)
    );

    typedef struct {
        string      tag;
        logic [3:0] y;
        logic       tc;
        logic       mx;
        logic       mn;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    // Post-reset directed vectors for A: clr ld lv en dir | expected y tc
    typedef struct packed {
        logic       clr;
        logic       ld;
        logic [3:0] lv;
        logic       en;
        logic       dir;
        logic [3:0] ey;
        logic       etc;
    } vec_t;

    vec_t va[13];
    vec_t va2[5];

    task automatic apply_a(input string tag, input logic r, input vec_t v);
        @(negedge clk);
        rst_a = r; clr_a = v.clr; ld_a = v.ld; lv_a = v.lv; en_a = v.en; dir_a = v.dir;
        qa.push_back('{tag, v.ey, v.etc, v.ey == 4'd9, v.ey == 4'd0});
    endtask

    task automatic apply_b(input string tag, input logic c, input logic l, input logic [3:0] lv,
                           input logic e, input logic d, input logic [3:0] ey, input logic etc);
        @(negedge clk);
        rst_b = 1'b0; clr_b = c; ld_b = l; lv_b = lv; en_b = e; dir_b = d;
        qb.push_back('{tag, ey, etc, ey == 4'd15, ey == 4'd0});
    endtask

    task automatic check_now(input string tag, input logic [3:0] ey, input logic etc,
                             input logic emx, input logic emn);
        checks++;
        if ({y_a, tc_a, mx_a, mn_a} !== {ey, etc, emx, emn}) begin
            errors++;
            $display("FAIL %s got y=%0d tc=%b max=%b min=%b want y=%0d tc=%b max=%b min=%b",
                     tag, y_a, tc_a, mx_a, mn_a, ey, etc, emx, emn);
        end else begin
            $display("ok   %s y=%0d tc=%b max=%b min=%b", tag, y_a, tc_a, mx_a, mn_a);
        end
    endtask

    // Monitor: every clock, compare whatever each DUT presents against the queue head
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (qa.size() != 0) begin
            e = qa.pop_front();
            checks++;
            if ({y_a, tc_a, mx_a, mn_a} !== {e.y, e.tc, e.mx, e.mn}) begin
                errors++;
                $display("FAIL A.%s got y=%0d tc=%b max=%b min=%b want y=%0d tc=%b max=%b min=%b",
                         e.tag, y_a, tc_a, mx_a, mn_a, e.y, e.tc, e.mx, e.mn);
            end else begin
                $display("ok   A.%s y=%0d tc=%b max=%b min=%b", e.tag, y_a, tc_a, mx_a, mn_a);
            end
        end
        if (qb.size() != 0) begin
            e = qb.pop_front();
            checks++;
            if ({y_b, tc_b, mx_b, mn_b} !== {e.y, e.tc, e.mx, e.mn}) begin
                errors++;
                $display("FAIL B.%s got y=%0d tc=%b max=%b min=%b want y=%0d tc=%b max=%b min=%b",
                         e.tag, y_b, tc_b, mx_b, mn_b, e.y, e.tc, e.mx, e.mn);
            end else begin
                $display("ok   B.%s y=%0d tc=%b max=%b min=%b", e.tag, y_b, tc_b, mx_b, mn_b);
            end
        end
    end

    task automatic run_a();
        vec_t v;
        // wrap up through 9 -> 0 -> 2, then down 1, 0, 9, 8, then load/clear cases
        va = '{
            '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd0, 1'b1},  // wrap 9 -> 0
            '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd1, 1'b0},
            '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd2, 1'b0},
            '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd1, 1'b0},
            '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd0, 1'b0},
            '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd9, 1'b1},  // wrap 0 -> 9
            '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd8, 1'b0},
            '{1'b0, 1'b1, 4'd12, 1'b1, 1'b1, 4'd9, 1'b0},  // load clamps to 9
            '{1'b1, 1'b1, 4'd3,  1'b1, 1'b1, 4'd0, 1'b0},  // clear beats load
            '{1'b0, 1'b1, 4'd9,  1'b0, 1'b0, 4'd9, 1'b0},
            '{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 4'd0, 1'b0},  // clear suppresses boundary tc
            '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 4'd0, 1'b0},
            '{1'b0, 1'b1, 4'd5,  1'b1, 1'b0, 4'd5, 1'b0}   // load suppresses boundary tc
        };
        va2 = '{
            '{1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd4, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd5, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0}    // dir flipped at y=5
        };
        #7 rst_a = 1'b0;
        check_now("A.reset", 4'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            v = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'(i), 1'b0};
            apply_a($sformatf("up%0d", i), 1'b0, v);
        end
        for (int i = 0; i < 13; i++) apply_a($sformatf("va%0d", i), 1'b0, va[i]);
        // asynchronous reset mid-cycle while y=5
        @(posedge clk);
        #3 rst_a = 1'b1;
        #1 check_now("A.async_rst", 4'd0, 1'b0, 1'b0, 1'b1);
        v = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0};
        apply_a("rst_hold0", 1'b1, v);
        apply_a("rst_hold1", 1'b1, v);
        for (int i = 0; i < 5; i++) apply_a($sformatf("vb%0d", i), 1'b0, va2[i]);
        @(negedge clk);
        en_a = 1'b0; ld_a = 1'b0;
    endtask

    task automatic run_b();
        #7 rst_b = 1'b0;
        for (int i = 1; i <= 15; i++) apply_b($sformatf("up%0d", i), 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'(i), 1'b0);
        for (int i = 0; i < 3; i++) apply_b($sformatf("sat_hi%0d", i), 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd15, 1'b1);
        apply_b("down_off_max", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd14, 1'b0);
        apply_b("load0",        1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0,  1'b0);
        apply_b("sat_lo0",      1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0,  1'b1);
        apply_b("sat_lo1",      1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0,  1'b1);
        apply_b("idle",         1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0,  1'b0);
        @(negedge clk);
        en_b = 1'b0;
    endtask

    initial begin
        fork
            run_a();
            run_b();
        join
        repeat (3) @(posedge clk);
        #2;
        if (qa.size() != 0 || qb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d/%0d pending want 0/0", qa.size(), qb.size());
        end
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        if (!done) begin
            $display("FAIL timeout got no completion want completion by 20000ns");
            $fatal(1, "timeout");
        end
    end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised successor to the team's 4-bit up/down counter. Width and modulo limit are configurable. Adds count enable, synchronous clear, parallel load, and a selectable wrap or saturate mode. Provides a terminal-count pulse and boundary flags, so it can act as a timebase or cascade stage in the same datapath as the existing counter.

Parameters:
WIDTH, 4, counter width in bits; legal range 1..32
MAX_VAL, 2**WIDTH-1, top of count range (range is 0..MAX_VAL); legal 1..2**WIDTH-1; elaboration error otherwise
SAT_MODE, 0, 0 = wrap at boundaries, 1 = saturate (hold) at boundaries

Ports:
clk  input  1  rising-edge clock; single clock domain
reset_n  input  1  asynchronous, active-HIGH reset (asserted = 1, despite the _n suffix, matching existing counter usage)
en  input  1  count enable; a step is taken only when en=1
dir  input  1  1 = count up, 0 = count down
clear  input  1  synchronous clear to 0
load  input  1  synchronous parallel load
load_val  input  WIDTH  value loaded when load=1
y  output  WIDTH  current count (registered)
tc  output  1  registered one-cycle terminal-count pulse
at_max  output  1  y == MAX_VAL (combinational from y)
at_min  output  1  y == 0 (combinational from y)

Behaviour:
- reset_n=1, asynchronous: y=0 and tc=0 immediately; at_min=1, at_max=0. Deassertion takes effect at the next posedge; the first step occurs at the first posedge with reset_n=0.
- Per posedge, priority is reset_n > clear > load > en.
- clear=1: y<=0, tc<=0; load, en and dir are ignored.
- load=1 (clear=0): y<=min(load_val, MAX_VAL); tc<=0; no step is taken that cycle.
- en=1, dir=1, y<MAX_VAL: y<=y+1, tc<=0.
- en=1, dir=0, y>0: y<=y-1, tc<=0.
- Up step at y==MAX_VAL:
  - SAT_MODE=0: y<=0 and tc<=1.
  - SAT_MODE=1: y holds at MAX_VAL and tc<=1 (tc flags the blocked step).
- Down step at y==0:
  - SAT_MODE=0: y<=MAX_VAL and tc<=1.
  - SAT_MODE=1: y holds at 0 and tc<=1.
- en=0 (no clear/load): y holds, tc<=0. tc is therefore never high for two cycles unless consecutive boundary steps occur. In saturate mode with en held at a boundary, tc stays high each cycle.
- dir is sampled only at the posedge. Changing dir mid-run takes effect on the next enabled step; there is no extra latency and no glitch on y.
- Latency: all y and tc updates are visible one clock after the sampled controls. at_max and at_min follow y combinationally.
- Arithmetic is WIDTH-bit unsigned. Values above MAX_VAL are unreachable except through load, which clamps.
- MAX_VAL < 2**WIDTH-1 (non-power-of-2 modulus): wrap goes to 0 and MAX_VAL, never to 2**WIDTH-1.
- Reset mid-count overrides everything at once. A clear or load arriving in the same cycle as a boundary step suppresses tc.

Decomposition:
- Shared package counter_pkg holds the mode constants (CNT_WRAP=0, CNT_SAT=1) and a function clog2 for callers sizing WIDTH from a modulus.
- The next-state computation sits in one natural sub-module, cnt_next_logic. It is combinational: it takes y, dir, en and mode, and returns y_next and tc_next.
- The top module holds the registers, the priority mux and the boundary flags.

Test Plan:
- Config WIDTH=4, MAX_VAL=9, SAT_MODE=0. Reset held 7 ns, then en=1, dir=1 for 12 clocks -> y goes 1..9, 0, 1, 2. tc=1 only in the cycle y shows 0. at_max=1 while y=9.
- Same config, dir=0 from y=2 for 4 clocks -> y goes 1, 0, 9, 8. tc=1 in the cycle y shows 9.
- Config SAT_MODE=1, MAX_VAL=15. Count up 18 clocks -> y stops at 15 and holds. tc=1 on each clock after y reaches 15. Then dir=0 for one clock -> y=14, tc=0.
- load=1, load_val=12 with MAX_VAL=9 -> y=9 next cycle, tc=0. load and clear together with en=1 -> y=0 (clear wins).
- Assert reset_n=1 asynchronously mid-cycle while y=5 -> y=0 before the next posedge, at_min=1. en=1 with reset held -> y stays 0.
- en toggled 1, 0, 1 while dir=1 from y=3 -> y goes 4, 4, 5. Flip dir on the cycle at y=5 -> next value is 4.
